// File: rtl/result_collector_pkg.sv
// Shared tile geometry and element types for the PE-grid drain path.
// The grid, Core and the activation shift buffer all size their datapaths from this package.
package result_collector_pkg;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DW     = 8;
    localparam int RCNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef logic [DW-1:0]          data_t;
    typedef data_t [COLS-1:0]       row_t;
    typedef data_t [ROWS*COLS-1:0]  tile_t;

endpackage

// File: rtl/result_collector_if.sv
// Column inputs from the PE grid and tile output toward Core.result, bundled as one port.
// master drives the columns and consumes the tile; slave is the collector.
interface result_collector_if;
    import result_collector_pkg::*;

    row_t              col_val;
    logic [COLS-1:0]   col_valid;
    tile_t             result;
    logic              result_valid;
    logic              result_ready;
    logic              overrun;
    logic              skew_err;

    modport master (
        output col_val, col_valid, result_ready,
        input  result, result_valid, overrun, skew_err
    );

    modport slave (
        input  col_val, col_valid, result_ready,
        output result, result_valid, overrun, skew_err
    );

endinterface

// File: rtl/result_collector_deskew_delay.sv
// DEPTH-stage register line carrying {valid, data}; DEPTH of zero is a plain wire.
// One instance per grid column cancels that column's skew.
module deskew_delay #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] din,
    input  logic          vin,
    output logic [DW-1:0] dout,
    output logic          vout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign dout = din;
            assign vout = vin;
        end else begin : g_line
            logic [DW:0] line_q [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
                end else begin
                    line_q[0] <= {vin, din};
                    for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
                end
            end

            assign vout = line_q[DEPTH-1][DW];
            assign dout = line_q[DEPTH-1][DW-1:0];
        end
    endgenerate

endmodule

// File: rtl/result_collector.sv
// Deskews the bottom-of-grid column outputs, assembles ROWS aligned rows into a tile and
// hands the tile to Core.result over valid/ready, flagging dropped tiles and misaligned rows.
module result_collector
    import result_collector_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    result_collector_if.slave  bus
);

    row_t              a_val;
    logic [COLS-1:0]   a_valid;

    genvar gc;
    generate
        for (gc = 0; gc < COLS; gc++) begin : g_col
            deskew_delay #(
                .DEPTH (COLS - 1 - gc),
                .DW    (DW)
            ) u_deskew (
                .clk   (clk),
                .reset (reset),
                .din   (bus.col_val[gc]),
                .vin   (bus.col_valid[gc]),
                .dout  (a_val[gc]),
                .vout  (a_valid[gc])
            );
        end
    endgenerate

    logic [RCNT_W-1:0] rcnt;
    tile_t             staging;
    tile_t             staging_next;
    tile_t             result_q;
    logic              result_valid_q;
    logic              overrun_q;
    logic              skew_err_q;

    logic              all_v;
    logic              any_v;
    logic              capture;
    logic              last_row;
    logic              out_free;

    assign all_v    = &a_valid;
    assign any_v    = |a_valid;
    assign capture  = all_v;
    assign last_row = capture && (rcnt == RCNT_W'(ROWS - 1));
    assign out_free = !result_valid_q || bus.result_ready;

    // staging_next already holds the incoming row, so on the last row it is the full tile
    always_comb begin
        staging_next = staging;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (capture && (rcnt == RCNT_W'(r))) begin
                    staging_next[r*COLS + c] = a_val[c];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt    <= '0;
            staging <= '0;
        end else if (capture) begin
            staging <= staging_next;
            rcnt    <= last_row ? '0 : rcnt + RCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            skew_err_q     <= 1'b0;
        end else begin
            if (any_v && !all_v) begin
                skew_err_q <= 1'b1;
            end
            // A completing tile may replace one being accepted on the same edge
            if (last_row && out_free) begin
                result_q       <= staging_next;
                result_valid_q <= 1'b1;
            end else if (last_row) begin
                overrun_q      <= 1'b1;
            end else if (result_valid_q && bus.result_ready) begin
                result_valid_q <= 1'b0;
            end
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.overrun      = overrun_q;
    assign bus.skew_err     = skew_err_q;

endmodule
